sdp_ram_ctrl: RTL and testbench

SDP_RAM_CTRL -- requirements
Module: sdp_ram_ctrl

---
 rtl/sdp_ram_ctrl.sv | 127 ++++++++++++
 tb/tb_sdp_ram_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_ctrl.sv
// Simple dual-port RAM controller: registered request stage, 2-cycle read latency, self-initialising array.
// Optional macro SDP_RAM_BYPASS_EN selects write-first forwarding on same-address collisions (default read-first).
module sdp_ram_ctrl #(
  parameter int                ADDR_W   = 17,
  parameter int                DATA_W   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_val,
  input  logic              write_en,
  output logic [DATA_W-1:0] read_val,
  output logic              read_valid,
  output logic              init_busy,
  output logic              state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  logic              rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_val_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Counter sweeps every address once; it parks at all-ones when leaving INIT.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_busy  = 1'b0;
    case (state)
      S_INIT: begin
        init_busy = 1'b1;
        if (cnt == {ADDR_W{1'b1}}) state_next = S_RUN;
        else                       cnt_next   = cnt + 1'b1;
      end
      S_RUN:   ;
      default: state_next = S_INIT;
    endcase
  end

  // Requests are plain qualifiers with no back-pressure: a request is accepted
  // when its enable is sampled high on an edge where init_busy is low; requests
  // sampled while init_busy is high are dropped without any response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      rd_en_q <= read_en  & ~init_busy;
      wr_en_q <= write_en & ~init_busy;
    end
  end

  always_ff @(posedge clk) begin
    rd_addr_q <= read_addr;
    wr_addr_q <= write_addr;
    wr_val_q  <= write_val;
  end

  // The init sweep owns the write port while busy.
  always_comb begin
    mem_we = wr_en_q;
    mem_wa = wr_addr_q;
    mem_wd = wr_val_q;
    if (init_busy) begin
      mem_we = 1'b1;
      mem_wa = cnt;
      mem_wd = INIT_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rd_en_q) begin
`ifdef SDP_RAM_BYPASS_EN
      if (wr_en_q && (wr_addr_q == rd_addr_q)) rd_data_q <= wr_val_q;
      else                                     rd_data_q <= mem[rd_addr_q];
`else
      rd_data_q <= mem[rd_addr_q];
`endif
    end
  end

  // read_val only updates on a completing read, so it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      read_valid <= 1'b0;
      read_val   <= '0;
    end else begin
      rd_valid_q <= rd_en_q;
      read_valid <= rd_valid_q;
      if (rd_valid_q) read_val <= rd_data_q;
    end
  end

endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Testbench for sdp_ram_ctrl: directed steps plus random traffic against an array/queue reference model.
module tb_sdp_ram_ctrl;

  localparam int         AW = 4;
  localparam int         DW = 8;
  localparam int         DEPTH = 16;
  localparam logic [7:0] IV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] read_addr = '0;
  logic          read_en = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_val = '0;
  logic          write_en = 1'b0;
  logic [DW-1:0] read_val;
  logic          read_valid;
  logic          init_busy;
  logic          state_dbg;

  sdp_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst),
    .read_addr(read_addr), .read_en(read_en),
    .write_addr(write_addr), .write_val(write_val), .write_en(write_en),
    .read_val(read_val), .read_valid(read_valid), .init_busy(init_busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          init_left = DEPTH;
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last_val = '0;
  logic [DW-1:0] exp_q [$];
  int            due_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic edge_checks();
    logic exp_v;
    exp_v = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_v    = 1'b1;
      last_val = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    check("read_valid", 32'(read_valid), 32'(exp_v));
    check(exp_v ? "read_val" : "read_val_hold", 32'(read_val), 32'(last_val));
    check("init_busy", 32'(init_busy), 32'(init_left > 0));
    check("state_dbg", 32'(state_dbg), 32'(init_left == 0));
  endtask

  // One clock edge: drive, let the DUT sample, advance the model, then check.
  task automatic cycle(input logic ren, input logic [AW-1:0] ra,
                       input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wv);
    logic [DW-1:0] v;
    read_en = ren; read_addr = ra; write_en = wen; write_addr = wa; write_val = wv;
    @(posedge clk);
    cyc++;
    if (init_left > 0) begin
      mdl[DEPTH - init_left] = IV;
      init_left--;
    end else begin
      if (ren) begin
        v = mdl[ra];
`ifdef SDP_RAM_BYPASS_EN
        if (wen && wa == ra) v = wv;
`endif
        exp_q.push_back(v);
        due_q.push_back(cyc + 2);
      end
      if (wen) mdl[wa] = wv;
    end
    #1;
    edge_checks();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    last_val = '0;
    exp_q.delete();
    due_q.delete();
    init_left = DEPTH;
    check("rst_read_val", 32'(read_val), 32'h0);
    check("rst_read_valid", 32'(read_valid), 32'h0);
    check("rst_init_busy", 32'(init_busy), 32'h1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Power-up reset and init sweep, with requests during init that must be dropped.
    do_reset(3);
    cycle(1'b1, 4'd3, 1'b1, 4'd3, 8'hFF);
    cycle(1'b1, 4'd9, 1'b1, 4'd9, 8'h00);
    idle(14);
    check("init_done", 32'(init_busy), 32'h0);

    // Back-to-back reads of every address.
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 4'(a), 1'b0, '0, '0);
    idle(3);

    // Write then read of address 7.
    cycle(1'b0, '0, 1'b1, 4'd7, 8'h3C);
    idle(1);
    cycle(1'b1, 4'd7, 1'b0, '0, '0);
    idle(3);

    // Same-cycle collision on address 5, then a follow-up read.
    cycle(1'b0, '0, 1'b1, 4'd5, 8'h11);
    idle(1);
    cycle(1'b1, 4'd5, 1'b1, 4'd5, 8'h22);
    cycle(1'b1, 4'd5, 1'b0, '0, '0);
    idle(3);

    // Different-address read and write in the same cycle.
    cycle(1'b1, 4'd7, 1'b1, 4'd8, 8'h5A);
    cycle(1'b1, 4'd8, 1'b0, '0, '0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));

    // Reset with reads in flight: they must never complete.
    cycle(1'b1, 4'd2, 1'b0, '0, '0);
    cycle(1'b1, 4'd4, 1'b0, '0, '0);
    do_reset(2);

    // Interrupt init at counter 9, then confirm a full fresh sweep.
    idle(9);
    do_reset(2);
    idle(16);
    cycle(1'b1, 4'd12, 1'b0, '0, '0);
    cycle(1'b1, 4'd3, 1'b0, '0, '0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
